// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline-control types and constants
// Purpose: state encoding, register-zero constant and hazard priority
//          levels used by the IF/ID, ID/EX and EX/MEM control blocks.
// Ports:   none (package).
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LU_STALL   = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_FETCH_WAIT = 2'd3
    } pipe_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Hazard classes, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        PRIO_DMEM_WAIT  = 3'd0,
        PRIO_BRANCH     = 3'd1,
        PRIO_LOAD_USE   = 3'd2,
        PRIO_FETCH_WAIT = 3'd3,
        PRIO_NONE       = 3'd4
    } hazard_prio_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for performance statistics
// Purpose: counts cycles where inc_i is high; holds at all-ones.
// Ports:   clk_i, rst_ni (async active-low), inc_i, count_o[W-1:0].
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + ONE;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - IF/ID and PC hazard sequencer
// Purpose: detects load-use, taken-branch and memory-wait hazards and drives
//          PC / IF/ID / ID/EX / EX/MEM controls with fixed priority; keeps
//          stall/flush counters and a sticky memory-wait watchdog.
// Ports:   clk, reset (async active-low); ID operands id_rs1/id_rs2/
//          id_uses_rs2; EX load info idex_mem_read/idex_rd; ex_branch_taken;
//          memory handshakes imem_ready, dmem_req, dmem_ready; control outs
//          pc_write, ifid_write, ifid_stall, ifid_flush, idex_bubble,
//          exmem_hold; stats stall_count, flush_count, timeout.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             timeout
);

    localparam int              WAIT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT - 1);

    pipe_state_e       state_q, state_d;
    hazard_prio_e      prio;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic              load_use;
    logic              in_wait;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = idex_mem_read && (idex_rd != REG_ZERO) &&
                      ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));

    // A load-use hit in LU_STALL is the same load still sitting in EX:
    // it was already covered by the single bubble, so it is ignored here.
    always_comb begin
        if (dmem_req && !dmem_ready) begin
            prio = PRIO_DMEM_WAIT;
        end else if (ex_branch_taken) begin
            prio = PRIO_BRANCH;
        end else if (load_use && (state_q != ST_LU_STALL)) begin
            prio = PRIO_LOAD_USE;
        end else if (!imem_ready) begin
            prio = PRIO_FETCH_WAIT;
        end else begin
            prio = PRIO_NONE;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        state_d     = ST_RUN;
        case (prio)
            PRIO_DMEM_WAIT: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_stall = 1'b1;
                exmem_hold = 1'b1;
                state_d    = ST_MEM_WAIT;
            end
            PRIO_BRANCH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            PRIO_LOAD_USE: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
                state_d     = ST_LU_STALL;
            end
            PRIO_FETCH_WAIT: begin
                // IF/ID is written with a NOP so the stale fetch never issues.
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                state_d    = ST_FETCH_WAIT;
            end
            default: ;
        endcase
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_stall  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            exmem_hold  = 1'b0;
        end
    end

    // The watchdog counts cycles spent stalled on memory and raises timeout
    // in the same cycle the count reaches MAX_WAIT-1, so timeout is visible
    // during the MAX_WAIT-th consecutive wait cycle.
    always_comb begin
        in_wait = (state_d == ST_MEM_WAIT) || (state_d == ST_FETCH_WAIT);
        if (!in_wait) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        timeout_d = timeout_q || (in_wait && (wait_cnt_d == WAIT_MAX));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .inc_i   (!pc_write),
        .count_o (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .inc_i   (prio == PRIO_BRANCH),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
// Purpose: drives hand-built hazard vectors and compares every control output
//          and counter against hand-computed values.
// Ports:   none (top-level bench).
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, idex_rd;
    logic        id_uses_rs2, idex_mem_read, ex_branch_taken;
    logic        imem_ready, dmem_req, dmem_ready;
    logic        pc_write, ifid_write, ifid_stall, ifid_flush;
    logic        idex_bubble, exmem_hold, timeout;
    logic [31:0] stall_count, flush_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(32), .MAX_WAIT(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .idex_mem_read   (idex_mem_read),
        .idex_rd         (idex_rd),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .exmem_hold      (exmem_hold),
        .stall_count     (stall_count),
        .flush_count     (flush_count),
        .timeout         (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
        idex_mem_read = 1'b0; idex_rd = 5'd0; ex_branch_taken = 1'b0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc_write",    32'(pc_write),    32'd0);
        check("rst_ifid_write",  32'(ifid_write),  32'd0);
        check("rst_ifid_stall",  32'(ifid_stall),  32'd1);
        check("rst_ifid_flush",  32'(ifid_flush),  32'd0);
        check("rst_idex_bubble", 32'(idex_bubble), 32'd1);
        check("rst_exmem_hold",  32'(exmem_hold),  32'd0);
        check("rst_stall_count", stall_count,      32'd0);
        check("rst_flush_count", flush_count,      32'd0);
        check("rst_timeout",     32'(timeout),     32'd0);

        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("run_pc_write",    32'(pc_write),    32'd1);
        check("run_ifid_write",  32'(ifid_write),  32'd1);
        check("run_ifid_stall",  32'(ifid_stall),  32'd0);
        check("run_stall_count", stall_count,      32'd0);

        // Load-use on rs1 held two cycles: exactly one bubble.
        next_cycle();
        idex_mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5;
        @(negedge clk);
        check("lu_pc_write",    32'(pc_write),    32'd0);
        check("lu_ifid_write",  32'(ifid_write),  32'd0);
        check("lu_ifid_stall",  32'(ifid_stall),  32'd1);
        check("lu_idex_bubble", 32'(idex_bubble), 32'd1);
        next_cycle();
        @(negedge clk);
        check("lu2_pc_write",    32'(pc_write),    32'd1);
        check("lu2_idex_bubble", 32'(idex_bubble), 32'd0);
        check("lu2_stall_count", stall_count,      32'd1);

        // Destination x0 never hazards, even when rs1 is also x0.
        next_cycle();
        idex_rd = 5'd0; id_rs1 = 5'd0;
        @(negedge clk);
        check("x0_pc_write",    32'(pc_write),    32'd1);
        check("x0_idex_bubble", 32'(idex_bubble), 32'd0);

        // rs2 match only counts when rs2 is actually read.
        next_cycle();
        idex_rd = 5'd5; id_rs1 = 5'd1; id_rs2 = 5'd5; id_uses_rs2 = 1'b0;
        @(negedge clk);
        check("rs2_unused_pc_write", 32'(pc_write), 32'd1);
        next_cycle();
        id_uses_rs2 = 1'b1;
        @(negedge clk);
        check("rs2_used_pc_write",    32'(pc_write),    32'd0);
        check("rs2_used_idex_bubble", 32'(idex_bubble), 32'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("rs2_after_pc_write", 32'(pc_write), 32'd1);
        check("rs2_stall_count",    stall_count,   32'd2);

        // Fetch wait, then a taken branch aborts it.
        next_cycle();
        imem_ready = 1'b0;
        @(negedge clk);
        check("fw_pc_write",   32'(pc_write),   32'd0);
        check("fw_ifid_write", 32'(ifid_write), 32'd1);
        check("fw_ifid_flush", 32'(ifid_flush), 32'd1);
        next_cycle();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        check("br_pc_write",    32'(pc_write),    32'd1);
        check("br_ifid_flush",  32'(ifid_flush),  32'd1);
        check("br_idex_bubble", 32'(idex_bubble), 32'd1);
        check("br_flush_pre",   flush_count,      32'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("br_flush_count", flush_count,      32'd1);
        check("br_run_flush",   32'(ifid_flush),  32'd0);
        check("br_run_pc",      32'(pc_write),    32'd1);
        check("br_stall_count", stall_count,      32'd3);

        // Data-memory wait holds a taken branch for 4 cycles.
        next_cycle();
        dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("dm%0d_exmem_hold", k), 32'(exmem_hold), 32'd1);
            check($sformatf("dm%0d_ifid_stall", k), 32'(ifid_stall), 32'd1);
            check($sformatf("dm%0d_pc_write", k),   32'(pc_write),   32'd0);
            check($sformatf("dm%0d_ifid_flush", k), 32'(ifid_flush), 32'd0);
            check($sformatf("dm%0d_flush_count", k), flush_count,    32'd1);
            next_cycle();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        check("dm_rel_ifid_flush", 32'(ifid_flush), 32'd1);
        check("dm_rel_exmem_hold", 32'(exmem_hold), 32'd0);
        check("dm_rel_pc_write",   32'(pc_write),   32'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("dm_flush_count", flush_count, 32'd2);
        check("dm_stall_count", stall_count, 32'd7);
        check("dm_timeout",     32'(timeout), 32'd0);

        // Fresh reset, then 10 fetch-wait cycles against MAX_WAIT=8.
        reset = 1'b0;
        #1;
        check("rst2_stall_count", stall_count, 32'd0);
        check("rst2_flush_count", flush_count, 32'd0);
        next_cycle();
        reset = 1'b1;
        imem_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("wd%0d_timeout", k), 32'(timeout), (k >= 8) ? 32'd1 : 32'd0);
            check($sformatf("wd%0d_pc_write", k), 32'(pc_write), 32'd0);
            next_cycle();
        end
        imem_ready = 1'b1;
        @(negedge clk);
        check("wd_end_timeout",     32'(timeout),  32'd1);
        check("wd_end_stall_count", stall_count,   32'd10);
        check("wd_end_pc_write",    32'(pc_write), 32'd1);
        next_cycle();
        @(negedge clk);
        check("wd_sticky_timeout", 32'(timeout), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
